// File: rtl/fp_exception_pipe.sv
// IEEE-754 special-case resolver for add/sub/mul behind a valid/ready pipeline.
// Sticky exception flags are updated from each result as it leaves the block.
module fp_exception_pipe #(
  parameter  int EXP_W  = 8,
  parameter  int MAN_W  = 23,
  parameter  int STAGES = 2,
  localparam int W      = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  input  logic [W-1:0] normal_result,
  input  logic         is_result_zero,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         use_normal_path,
  input  logic         flags_clr,
  output logic         flag_invalid,
  output logic         flag_nan_in,
  output logic         flag_inf
);

  // Stage payload: {ev_inf, ev_nan, ev_invalid, use_normal, result}
  localparam int P = W + 4;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic a_inf, a_nan, a_snan, a_zero;
  logic b_inf, b_nan, b_snan, b_zero;
  logic sa, sb, sm;
  logic [W-1:0] res_d;
  logic use_normal_d, ev_invalid_d, ev_nan_d, ev_inf_d;

  assign exp_a  = a[W-2:MAN_W];
  assign exp_b  = b[W-2:MAN_W];
  assign frac_a = a[MAN_W-1:0];
  assign frac_b = b[MAN_W-1:0];

  always_comb begin
    a_inf  = (&exp_a) && !(|frac_a);
    a_nan  = (&exp_a) && (|frac_a);
    a_snan = a_nan && !frac_a[MAN_W-1];
    a_zero = !(|exp_a) && !(|frac_a);
    b_inf  = (&exp_b) && !(|frac_b);
    b_nan  = (&exp_b) && (|frac_b);
    b_snan = b_nan && !frac_b[MAN_W-1];
    b_zero = !(|exp_b) && !(|frac_b);
  end

  // Override selection in priority order; falls through to the datapath result.
  always_comb begin
    sa           = a[W-1];
    sb           = b[W-1] ^ (op == 2'b01);
    sm           = a[W-1] ^ b[W-1];
    res_d        = normal_result;
    use_normal_d = 1'b1;
    ev_invalid_d = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        use_normal_d = 1'b0;
        if (a_nan || b_nan) begin
          res_d = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
          res_d        = QNAN;
          ev_invalid_d = 1'b1;
        end else if (a_inf) begin
          res_d = {sa, EXP_ONES, {MAN_W{1'b0}}};
        end else if (b_inf) begin
          res_d = {sb, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero && b_zero) begin
          res_d = {sa & sb, {(W-1){1'b0}}};
        end else if (is_result_zero) begin
          res_d = '0;
        end else begin
          use_normal_d = 1'b1;
        end
      end
      2'b10: begin
        use_normal_d = 1'b0;
        if (a_nan || b_nan) begin
          res_d = QNAN;
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
          res_d        = QNAN;
          ev_invalid_d = 1'b1;
        end else if (a_inf || b_inf) begin
          res_d = {sm, EXP_ONES, {MAN_W{1'b0}}};
        end else if (a_zero || b_zero || is_result_zero) begin
          res_d = {sm, {(W-1){1'b0}}};
        end else begin
          use_normal_d = 1'b1;
        end
      end
      default: ;
    endcase
    ev_nan_d     = (op != 2'b11) && (a_nan || b_nan);
    ev_invalid_d = ev_invalid_d || ((op != 2'b11) && (a_snan || b_snan));
    ev_inf_d     = (op != 2'b11) && (&res_d[W-2:MAN_W]) && !(|res_d[MAN_W-1:0]);
  end

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] stage_ready;
  logic [P-1:0]      data_q [STAGES];
  logic [P-1:0]      data_d [STAGES];

  // A stage may load when any stage from it to the output has a bubble, or the consumer takes.
  always_comb begin
    stage_ready = '0;
    for (int k = 0; k < STAGES; k++) begin
      stage_ready[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!valid_q[j]) stage_ready[k] = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) data_d[k] = data_q[k];
    if (stage_ready[0]) begin
      valid_d[0] = in_valid;
      data_d[0]  = {ev_inf_d, ev_nan_d, ev_invalid_d, use_normal_d, res_d};
    end
    for (int k = 1; k < STAGES; k++) begin
      if (stage_ready[k]) begin
        valid_d[k] = valid_q[k-1];
        data_d[k]  = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  logic       handshake;
  logic [2:0] flags_q, flags_d;

  assign handshake = valid_q[STAGES-1] && out_ready;

  always_comb begin
    flags_d = (flags_q & ~{3{flags_clr}}) | ({3{handshake}} & data_q[STAGES-1][W+3:W+1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign in_ready        = stage_ready[0];
  assign out_valid       = valid_q[STAGES-1];
  assign result          = data_q[STAGES-1][W-1:0];
  assign use_normal_path = data_q[STAGES-1][W];
  assign flag_inf        = flags_q[2];
  assign flag_nan_in     = flags_q[1];
  assign flag_invalid    = flags_q[0];

endmodule

// File: tb/tb_fp_exception_pipe.sv
// Bench for fp_exception_pipe: FP32/2-stage instance against a scoreboard model,
// plus a half-precision 4-stage instance for latency and reset behaviour.
module tb_fp_exception_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, normal_result, result;
  logic [1:0]  op;
  logic        is_result_zero, use_normal_path, flags_clr;
  logic        flag_invalid, flag_nan_in, flag_inf;

  logic        in_valid_h, in_ready_h, out_valid_h, out_ready_h;
  logic [15:0] a_h, b_h, normal_result_h, result_h;
  logic [1:0]  op_h;
  logic        is_result_zero_h, use_normal_path_h, flags_clr_h;
  logic        flag_invalid_h, flag_nan_in_h, flag_inf_h;

  always #5 clk = ~clk;

  fp_exception_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .normal_result(normal_result), .is_result_zero(is_result_zero),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .use_normal_path(use_normal_path), .flags_clr(flags_clr),
    .flag_invalid(flag_invalid), .flag_nan_in(flag_nan_in), .flag_inf(flag_inf)
  );

  fp_exception_pipe #(.EXP_W(5), .MAN_W(10), .STAGES(4)) dut_h (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_h), .in_ready(in_ready_h),
    .a(a_h), .b(b_h), .op(op_h), .normal_result(normal_result_h),
    .is_result_zero(is_result_zero_h), .out_valid(out_valid_h), .out_ready(out_ready_h),
    .result(result_h), .use_normal_path(use_normal_path_h), .flags_clr(flags_clr_h),
    .flag_invalid(flag_invalid_h), .flag_nan_in(flag_nan_in_h), .flag_inf(flag_inf_h)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  typedef enum {C_ZERO, C_INF, C_QNAN, C_SNAN, C_FIN} cls_t;

  typedef struct packed {
    logic [31:0] res;
    logic        use_n;
    logic        ev_inv;
    logic        ev_nan;
    logic        ev_inf;
  } exp_t;

  function automatic cls_t classify(input int ew, input int mw, input logic [31:0] v);
    logic [31:0] e, f, emax;
    emax = (32'd1 << ew) - 32'd1;
    e    = (v >> mw) & emax;
    f    = v & ((32'd1 << mw) - 32'd1);
    if (e == emax) begin
      if (f == 32'd0) return C_INF;
      return f[mw-1] ? C_QNAN : C_SNAN;
    end
    if (e == 32'd0 && f == 32'd0) return C_ZERO;
    return C_FIN;
  endfunction

  function automatic exp_t model(input int ew, input int mw, input logic [31:0] av,
                                 input logic [31:0] bv, input logic [31:0] nr,
                                 input logic [1:0] opv, input logic rz);
    exp_t        r;
    int          w;
    logic        sa, sb, sm, nan_any;
    logic [31:0] inf_mag, qnan, sgn;
    cls_t        ca, cb;
    w       = 1 + ew + mw;
    sa      = av[w-1];
    sb      = bv[w-1] ^ (opv == 2'd1);
    sm      = av[w-1] ^ bv[w-1];
    inf_mag = ((32'd1 << ew) - 32'd1) << mw;
    qnan    = inf_mag | (32'd1 << (mw - 1));
    sgn     = 32'd1 << (w - 1);
    ca      = classify(ew, mw, av);
    cb      = classify(ew, mw, bv);
    nan_any = (ca == C_QNAN) || (ca == C_SNAN) || (cb == C_QNAN) || (cb == C_SNAN);
    r.res = nr; r.use_n = 1'b1; r.ev_inv = 1'b0; r.ev_nan = 1'b0; r.ev_inf = 1'b0;
    if (opv == 2'd3) return r;
    r.use_n = 1'b0;
    if (opv != 2'd2) begin
      if (nan_any) r.res = qnan;
      else if (ca == C_INF && cb == C_INF) begin
        if (sa != sb) begin r.res = qnan; r.ev_inv = 1'b1; end
        else r.res = (sa ? sgn : 32'd0) | inf_mag;
      end
      else if (ca == C_INF) r.res = (sa ? sgn : 32'd0) | inf_mag;
      else if (cb == C_INF) r.res = (sb ? sgn : 32'd0) | inf_mag;
      else if (ca == C_ZERO && cb == C_ZERO) r.res = (sa && sb) ? sgn : 32'd0;
      else if (rz) r.res = 32'd0;
      else begin r.res = nr; r.use_n = 1'b1; end
    end else begin
      if (nan_any) r.res = qnan;
      else if ((ca == C_INF && cb == C_ZERO) || (ca == C_ZERO && cb == C_INF)) begin
        r.res = qnan; r.ev_inv = 1'b1;
      end
      else if (ca == C_INF || cb == C_INF) r.res = (sm ? sgn : 32'd0) | inf_mag;
      else if (ca == C_ZERO || cb == C_ZERO || rz) r.res = sm ? sgn : 32'd0;
      else begin r.res = nr; r.use_n = 1'b1; end
    end
    if (ca == C_SNAN || cb == C_SNAN) r.ev_inv = 1'b1;
    r.ev_nan = nan_any;
    r.ev_inf = ((r.res & ~sgn) == inf_mag);
    return r;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic        s;
    logic [22:0] f;
    s = 1'($urandom_range(0, 1));
    f = 23'($urandom);
    case ($urandom_range(0, 7))
      0:       return {s, 31'd0};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, 1'b1, f[21:0]};
      3:       return {s, 8'hFF, 1'b0, f[21:1], 1'b1};
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard for the FP32 instance: in-order expected results and modelled sticky flags.
  exp_t        exp_q[$];
  int          out_count = 0;
  logic [2:0]  mflags;
  logic        prev_stall;
  logic [31:0] prev_result;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      exp_q.delete();
      mflags     = 3'b000;
      prev_stall = 1'b0;
    end else begin
      check_bit("flag_invalid", flag_invalid, mflags[0]);
      check_bit("flag_nan_in", flag_nan_in, mflags[1]);
      check_bit("flag_inf", flag_inf, mflags[2]);
      if (prev_stall) begin
        check_bit("hold_valid", out_valid, 1'b1);
        check_word("hold_result", result, prev_result);
      end
      mflags = mflags & ~{3{flags_clr}};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_bit("spurious_out", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check_word("result", result, e.res);
          check_bit("use_normal_path", use_normal_path, e.use_n);
          mflags = mflags | {e.ev_inf, e.ev_nan, e.ev_inv};
          out_count++;
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(8, 23, a, b, normal_result, op, is_result_zero));
      prev_stall  = out_valid && !out_ready;
      prev_result = result;
    end
  end

  task automatic apply_stimulus(input string tag, input logic [31:0] av, input logic [31:0] bv,
                                input logic [1:0] opv, input logic [31:0] nr, input logic rz,
                                input logic [31:0] exp_res, input logic exp_use);
    int k;
    out_ready = 1'b1;
    a = av; b = bv; op = opv; normal_result = nr; is_result_zero = rz; in_valid = 1'b1;
    @(negedge clk);
    check_bit({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 1;
    while (k <= 20) begin
      @(negedge clk);
      if (out_valid) break;
      k++;
    end
    check_word({tag, "_latency"}, k, 32'd2);
    check_word({tag, "_result"}, result, exp_res);
    check_bit({tag, "_use_normal"}, use_normal_path, exp_use);
    @(posedge clk); #1;
  endtask

  task automatic clear_flags();
    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk); #1;
    check_word("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int k;
    int start_count;
    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; op = '0; normal_result = '0; is_result_zero = 1'b0;
    out_ready = 1'b1; flags_clr = 1'b0;
    in_valid_h = 1'b0; a_h = '0; b_h = '0; op_h = '0; normal_result_h = '0;
    is_result_zero_h = 1'b0; out_ready_h = 1'b1; flags_clr_h = 1'b0;

    #2;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_word("rst_result", result, 32'd0);
    check_bit("rst_use_normal", use_normal_path, 1'b0);
    check_bit("rst_flag_invalid", flag_invalid, 1'b0);
    check_bit("rst_flag_nan_in", flag_nan_in, 1'b0);
    check_bit("rst_flag_inf", flag_inf, 1'b0);
    check_bit("rst_out_valid_h", out_valid_h, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check_bit("in_ready_after_reset", in_ready, 1'b1);
    check_bit("in_ready_after_reset_h", in_ready_h, 1'b1);
    @(posedge clk); #1;

    clear_flags();
    apply_stimulus("add_inf_minf", 32'h7F800000, 32'hFF800000, 2'd0, 32'd0, 1'b0, 32'h7FC00000, 1'b0);
    check_bit("add_inf_minf_invalid", flag_invalid, 1'b1);
    apply_stimulus("sub_inf_inf", 32'h7F800000, 32'h7F800000, 2'd1, 32'd0, 1'b0, 32'h7FC00000, 1'b0);
    check_bit("sub_inf_inf_invalid", flag_invalid, 1'b1);
    clear_flags();
    apply_stimulus("add_minf_one", 32'hFF800000, 32'h3F800000, 2'd0, 32'd0, 1'b0, 32'hFF800000, 1'b0);
    check_bit("add_minf_one_inf", flag_inf, 1'b1);
    check_bit("add_minf_one_invalid", flag_invalid, 1'b0);
    apply_stimulus("mul_zero_minf", 32'h00000000, 32'hFF800000, 2'd2, 32'd0, 1'b0, 32'h7FC00000, 1'b0);
    check_bit("mul_zero_minf_invalid", flag_invalid, 1'b1);
    apply_stimulus("mul_mzero_two", 32'h80000000, 32'h40000000, 2'd2, 32'd0, 1'b0, 32'h80000000, 1'b0);
    apply_stimulus("add_mzero_mzero", 32'h80000000, 32'h80000000, 2'd0, 32'd0, 1'b0, 32'h80000000, 1'b0);
    apply_stimulus("add_mzero_pzero", 32'h80000000, 32'h00000000, 2'd0, 32'd0, 1'b0, 32'h00000000, 1'b0);
    clear_flags();
    apply_stimulus("snan_add", 32'h7F800001, 32'h3F800000, 2'd0, 32'd0, 1'b0, 32'h7FC00000, 1'b0);
    check_bit("snan_add_invalid", flag_invalid, 1'b1);
    check_bit("snan_add_nan_in", flag_nan_in, 1'b1);
    clear_flags();
    apply_stimulus("qnan_add", 32'h7FC00001, 32'h3F800000, 2'd0, 32'd0, 1'b0, 32'h7FC00000, 1'b0);
    check_bit("qnan_add_nan_in", flag_nan_in, 1'b1);
    check_bit("qnan_add_invalid", flag_invalid, 1'b0);
    apply_stimulus("reserved_op", 32'h7F800000, 32'hFF800000, 2'd3, 32'h12345678, 1'b0, 32'h12345678, 1'b1);
    apply_stimulus("normal_add", 32'h3F800000, 32'h3F800000, 2'd0, 32'h40000000, 1'b0, 32'h40000000, 1'b1);
    apply_stimulus("rz_add", 32'h3F800000, 32'hBF800000, 2'd0, 32'h12345678, 1'b1, 32'h00000000, 1'b0);
    apply_stimulus("mul_rz_neg", 32'hBF800000, 32'h00800000, 2'd2, 32'h00000001, 1'b1, 32'h80000000, 1'b0);

    // Eight back-to-back ordinary ops while the consumer toggles 1,0,0,1.
    start_count = out_count;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          out_ready = (i % 4 == 0) || (i % 4 == 3);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 8; i++) begin
          logic acc;
          int   guard;
          a = 32'h3F800000 + i; b = 32'h40000000; op = 2'd0;
          normal_result = $urandom; is_result_zero = 1'b0; in_valid = 1'b1;
          acc = 1'b0; guard = 0;
          while (!acc && guard < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
          end
          if (!acc) check_bit("stream_accept", acc, 1'b1);
        end
        in_valid = 1'b0;
      end
    join
    drain();
    check_word("stream_count", out_count - start_count, 32'd8);

    // Flag clear in the same cycle as an inf result departs: the event wins.
    clear_flags();
    out_ready = 1'b0;
    a = 32'hFF800000; b = 32'h3F800000; op = 2'd0; normal_result = '0; is_result_zero = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_bit("coinc_out_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1; flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    check_bit("coinc_flag_inf", flag_inf, 1'b1);
    check_bit("coinc_flag_invalid", flag_invalid, 1'b0);

    for (int i = 0; i < 500; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      a = rand_operand(); b = rand_operand(); op = 2'($urandom_range(0, 3));
      normal_result = $urandom; is_result_zero = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 3) != 0); flags_clr = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flags_clr = 1'b0; out_ready = 1'b1;
    drain();

    // Half precision, four stages.
    a_h = 16'h7C00; b_h = 16'hFC00; op_h = 2'd0; normal_result_h = '0; in_valid_h = 1'b1;
    @(negedge clk);
    check_bit("h_in_ready", in_ready_h, 1'b1);
    @(posedge clk); #1;
    in_valid_h = 1'b0;
    k = 1;
    while (k <= 20) begin
      @(negedge clk);
      if (out_valid_h) break;
      k++;
    end
    check_word("h_latency", k, 32'd4);
    check_word("h_result", {16'd0, result_h}, 32'h00007E00);
    check_bit("h_use_normal", use_normal_path_h, 1'b0);
    @(posedge clk); #1;
    check_bit("h_flag_invalid", flag_invalid_h, 1'b1);

    out_ready_h = 1'b0;
    a_h = 16'h3C00; b_h = 16'h3C00; normal_result_h = 16'h4000; in_valid_h = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check_bit("h_full_out_valid", out_valid_h, 1'b1);
    check_bit("h_full_in_ready", in_ready_h, 1'b0);
    out_ready_h = 1'b1;
    #1;
    check_bit("h_full_release_in_ready", in_ready_h, 1'b1);
    out_ready_h = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_bit("h_midrst_out_valid", out_valid_h, 1'b0);
    check_word("h_midrst_result", {16'd0, result_h}, 32'd0);
    check_bit("h_midrst_flag_invalid", flag_invalid_h, 1'b0);
    check_bit("h_midrst_flag_nan_in", flag_nan_in_h, 1'b0);
    check_bit("h_midrst_flag_inf", flag_inf_h, 1'b0);
    check_bit("midrst_flag_nan_in", flag_nan_in, 1'b0);
    check_bit("midrst_out_valid", out_valid, 1'b0);
    in_valid_h = 1'b0; out_ready_h = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_bit("post_rst_out_valid_h", out_valid_h, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
